tdm_demux8: RTL



---
 rtl/tdm_pkg.sv | 41 ++++
 rtl/tdm_demux8_dec3to8.sv | 23 ++
 rtl/tdm_demux8.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared constants, FSM encoding and helpers for the tdm_demux8 slice.
// TDM_PARITY_EN adds a 9th (even-parity) slot per frame and widens the slot counter.
package tdm_pkg;

   localparam int NUM_SLOTS = 8;
   localparam int SLOT_W    = 3;

`ifdef TDM_PARITY_EN
   localparam int FRAME_LEN = NUM_SLOTS + 1;
   localparam int CNT_W     = SLOT_W + 1;
`else
   localparam int FRAME_LEN = NUM_SLOTS;
   localparam int CNT_W     = SLOT_W;
`endif

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   // Slot-indexed lanes to the parallel byte; MSB-first reverses bit order.
   function automatic logic [7:0] map_lanes(input logic [7:0] lanes, input logic lsb_first);
      logic [7:0] rev;
      rev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         rev[7-i] = lanes[i];
      end
      if (lsb_first) begin
         return lanes;
      end else begin
         return rev;
      end
   endfunction

   function automatic logic even_par(input logic [7:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/tdm_demux8_dec3to8.sv
// Pure 3-to-8 one-hot decoder producing the lane write enables of tdm_demux8.
module dec3to8 (
   input  logic [2:0] sel_i,
   output logic [7:0] onehot_o
);

   // Slot index to one-hot lane select.
   always_comb begin
      onehot_o = 8'h00;
      case (sel_i)
         3'd0:    onehot_o = 8'b0000_0001;
         3'd1:    onehot_o = 8'b0000_0010;
         3'd2:    onehot_o = 8'b0000_0100;
         3'd3:    onehot_o = 8'b0000_1000;
         3'd4:    onehot_o = 8'b0001_0000;
         3'd5:    onehot_o = 8'b0010_0000;
         3'd6:    onehot_o = 8'b0100_0000;
         3'd7:    onehot_o = 8'b1000_0000;
         default: onehot_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/tdm_demux8.sv
// Time-division 1-to-8 demultiplexer: serial bits steered by a slot counter into lanes,
// complete frames presented as a byte with a one-cycle strobe. Optional macro: TDM_PARITY_EN.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             x,
   input  logic             sof,
   output logic [CNT_W-1:0] s,
   output logic [7:0]       d,
   output logic [7:0]       y,
   output logic             out_valid
`ifdef TDM_PARITY_EN
  ,output logic             parity_err
`endif
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] s_q, s_d;
   logic [7:0]       d_q, d_d;
   logic [7:0]       y_q, y_d;
   logic             ov_q, ov_d;
   logic             perr_q, perr_d;

   logic             accept_s;
   logic [CNT_W-1:0] slot_s;
   logic             last_s;
   logic             lane_ok_s;
   logic [7:0]       we_raw_s;
   logic [7:0]       we_s;
   logic [7:0]       lanes_s;

   // sof re-anchors the bit to slot 0 regardless of where the counter stands.
   assign accept_s = in_valid & ((state_q == FILL) | sof);
   assign slot_s   = sof ? '0 : s_q;
   assign last_s   = accept_s & (slot_s == LAST_SLOT);
`ifdef TDM_PARITY_EN
   assign lane_ok_s = ~slot_s[CNT_W-1];
`else
   assign lane_ok_s = 1'b1;
`endif

   dec3to8 u_dec (
      .sel_i    (slot_s[SLOT_W-1:0]),
      .onehot_o (we_raw_s)
   );

   assign we_s    = we_raw_s & {8{accept_s & lane_ok_s}};
   assign lanes_s = (d_q & ~we_s) | ({8{x}} & we_s);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: once a frame starts the receiver stays framed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid && sof) begin
               state_d = FILL;
            end else begin
               state_d = IDLE;
            end
         end
         FILL:    state_d = FILL;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: slot advance, lane capture and frame completion.
   always_comb begin
      s_d    = s_q;
      d_d    = d_q;
      y_d    = y_q;
      ov_d   = 1'b0;
      perr_d = 1'b0;
      if (accept_s) begin
         d_d = lanes_s;
         if (last_s) begin
            s_d  = '0;
            y_d  = map_lanes(lanes_s, LSB_FIRST);
            ov_d = 1'b1;
`ifdef TDM_PARITY_EN
            perr_d = x ^ even_par(d_q);
`else
            perr_d = 1'b0;
`endif
         end else begin
            s_d = slot_s + CNT_W'(1);
         end
      end else begin
         s_d = s_q;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= '0;
         d_q    <= 8'h00;
         y_q    <= 8'h00;
         ov_q   <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         d_q    <= d_d;
         y_q    <= y_d;
         ov_q   <= ov_d;
         perr_q <= perr_d;
      end
   end

   assign s         = s_q;
   assign d         = d_q;
   assign y         = y_q;
   assign out_valid = ov_q;
`ifdef TDM_PARITY_EN
   assign parity_err = perr_q;
`else
   logic unused_perr_s;
   assign unused_perr_s = perr_q;
`endif

endmodule
